// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, instruction FIFO and branch redirect.
// Optional perf counters (PerfDiscard/PerfStall) are built only when IFETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       INSTR_W    = 24,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic               Clock,
    input  logic               ResetN,
    output logic               ImemReq,
    output logic [ADDR_W-1:0]  ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    input  logic               Halt,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               InstrValid,
    input  logic               DecReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPc,
    output logic [3:0]         Opcode,
    output logic [15:0]        PerfDiscard,
    output logic [15:0]        PerfStall
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d;
    logic               req_q, req_d, discard_q, discard_d;
    logic [INSTR_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pcb_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d, count_pop;
    logic               pop, push, drop;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        discard_d = discard_q;
        push      = 1'b0;
        drop      = 1'b0;
        pop       = (count_q != '0) && DecReady && !BranchTaken;
        count_pop = pop ? count_q - CNT_W'(1) : count_q;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (!BranchTaken && !Halt && (count_pop < CNT_W'(FIFO_DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ImemAck) begin
                    drop      = discard_q || BranchTaken;
                    push      = !drop;
                    discard_d = 1'b0;
                    if (push) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                    // Back-to-back fetch only when the slot for the next response is guaranteed.
                    if (push && !Halt && ((count_pop + CNT_W'(1)) < CNT_W'(FIFO_DEPTH))) begin
                        addr_d = pc_q + ADDR_W'(1);
                    end else begin
                        req_d   = 1'b0;
                        state_d = FETCH;
                    end
                end else if (BranchTaken) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (BranchTaken) begin
            pc_d = BranchTarget;
        end
    end

    always_comb begin
        count_d = count_q;
        if (BranchTaken) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            if (BranchTaken) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            data_q[wr_ptr_q] <= ImemData;
            pcb_q[wr_ptr_q]  <= addr_q;
        end
    end

    assign ImemReq    = req_q;
    assign ImemAddr   = addr_q;
    assign InstrValid = (count_q != '0);
    assign Instr      = InstrValid ? data_q[rd_ptr_q] : '0;
    assign InstrPc    = InstrValid ? pcb_q[rd_ptr_q]  : '0;
    assign Opcode     = Instr[INSTR_W-1 -: 4];

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] perf_disc_q, perf_stall_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            perf_disc_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (drop && (perf_disc_q != 16'hFFFF)) begin
                perf_disc_q <= perf_disc_q + 16'd1;
            end
            if (InstrValid && !DecReady && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign PerfDiscard = perf_disc_q;
    assign PerfStall   = perf_stall_q;
`else
    assign PerfDiscard = '0;
    assign PerfStall   = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level program-stream model.
module tb_instr_fetch_unit;

    localparam int         AW    = 8;
    localparam int         IW    = 24;
    localparam int         DEPTH = 2;
    localparam logic [7:0] RPC   = 8'h10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ImemReq, ImemAck, Halt, BranchTaken, InstrValid, DecReady;
    logic [AW-1:0] ImemAddr, BranchTarget, InstrPc;
    logic [IW-1:0] ImemData, Instr;
    logic [3:0]    Opcode;
    logic [15:0]   PerfDiscard, PerfStall;

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(clk), .ResetN(rst_n),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
        .Halt(Halt), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .InstrValid(InstrValid), .DecReady(DecReady), .Instr(Instr), .InstrPc(InstrPc),
        .Opcode(Opcode), .PerfDiscard(PerfDiscard), .PerfStall(PerfStall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] d;
        logic [AW-1:0] pc;
    } ent_t;

    logic [IW-1:0] mem [256];
    ent_t          q[$];
    logic [AW-1:0] exp_fetch, prev_addr;
    bit            br_pending, prev_req, prev_ack, prev_halt;
    int            lat, m_disc, m_stall;
    int            p_dec, p_br, p_halt, max_lat, p_spur;
    int            n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_fetch  = RPC;
        br_pending = 0;
        prev_req   = 0;
        prev_ack   = 0;
        prev_halt  = 0;
        prev_addr  = RPC;
        lat        = 0;
        m_disc     = 0;
        m_stall    = 0;
    endtask

    task automatic set_knobs(input int dec, input int br, input int hlt, input int ml, input int sp);
        p_dec = dec; p_br = br; p_halt = hlt; max_lat = ml; p_spur = sp;
    endtask

    // One clock: check observed state, drive inputs, advance the model, step to posedge+1.
    task automatic cycle();
        bit   issue, pop;
        ent_t e;
        issue = ImemReq && (!prev_req || prev_ack);
        if (prev_req && !prev_ack) begin
            chk("req_hold", ImemReq, 1);
            chk("addr_hold", ImemAddr, prev_addr);
        end
        if (issue) begin
            chk("fetch_addr", ImemAddr, exp_fetch);
            chk("issue_under_halt", prev_halt, 0);
            lat = $urandom_range(max_lat, 0);
        end
        chk("valid", InstrValid, q.size() != 0);
        if (q.size() != 0) begin
            chk("instr", Instr, q[0].d);
            chk("instr_pc", InstrPc, q[0].pc);
            chk("opcode", Opcode, q[0].d[IW-1 -: 4]);
        end else begin
            chk("instr_empty", Instr, 0);
        end
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_discard", PerfDiscard, m_disc);
        chk("perf_stall", PerfStall, m_stall);
`else
        chk("perf_discard_off", PerfDiscard, 0);
        chk("perf_stall_off", PerfStall, 0);
`endif

        DecReady    = ($urandom_range(99) < p_dec);
        Halt        = ($urandom_range(99) < p_halt);
        BranchTaken = ($urandom_range(99) < p_br);
        BranchTarget = $urandom_range(1) ? AW'($urandom) : AW'($urandom_range(255, 248));
        if (ImemReq) begin
            if (lat <= 0) ImemAck = 1'b1;
            else begin
                ImemAck = 1'b0;
                lat--;
            end
        end else begin
            ImemAck = ($urandom_range(99) < p_spur);
        end
        ImemData = (ImemReq && ImemAck) ? mem[ImemAddr] : IW'($urandom);

        pop = (q.size() != 0) && DecReady && !BranchTaken;
        if (q.size() != 0 && !DecReady && m_stall < 65535) m_stall++;
        if (pop) void'(q.pop_front());
        if (ImemReq && ImemAck) begin
            if (BranchTaken || br_pending) begin
                if (m_disc < 65535) m_disc++;
                br_pending = 0;
            end else begin
                chk("no_overflow", q.size() < DEPTH, 1);
                e.d  = ImemData;
                e.pc = ImemAddr;
                q.push_back(e);
                exp_fetch = ImemAddr + 8'd1;
            end
        end
        if (BranchTaken) begin
            q.delete();
            exp_fetch = BranchTarget;
            if (ImemReq && !ImemAck) br_pending = 1;
        end
        prev_req  = ImemReq;
        prev_ack  = ImemReq && ImemAck;
        prev_halt = Halt;
        prev_addr = ImemAddr;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int k;
        n_vec = 0;
        n_err = 0;
        foreach (mem[i]) mem[i] = IW'($urandom);
        rst_n = 1'b0;
        ImemAck = 0; ImemData = '0; Halt = 0; BranchTaken = 0; BranchTarget = '0; DecReady = 0;
        set_knobs(100, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", ImemReq, 0);
        chk("rst_addr", ImemAddr, RPC);
        chk("rst_valid", InstrValid, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_instr_pc", InstrPc, 0);
        chk("rst_opcode", Opcode, 0);
        rst_n = 1'b1;
        model_reset();

        set_knobs(100, 0, 0, 0, 0);   run(40);
        set_knobs(0, 0, 0, 0, 0);     run(20);
        chk("full_req_off", ImemReq, 0);
        chk("full_valid", InstrValid, 1);
        set_knobs(100, 0, 0, 0, 0);   run(20);
        set_knobs(60, 3, 5, 3, 5);    run(1500);
        set_knobs(50, 20, 0, 2, 0);   run(1500);
        set_knobs(90, 2, 20, 0, 10);  run(800);

        set_knobs(100, 0, 0, 3, 0);
        k = 0;
        while (!ImemReq && k < 200) begin
            cycle();
            k++;
        end
        chk("rst_mid_wait_seen", ImemReq, 1);
        rst_n = 1'b0;
        ImemAck = 1'b0;
        #1;
        chk("rst_async_req", ImemReq, 0);
        chk("rst_async_valid", InstrValid, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_addr", ImemAddr, RPC);
        rst_n = 1'b1;
        model_reset();
        set_knobs(80, 5, 5, 1, 5);    run(500);

`ifdef IFETCH_PERF_CNT_EN
        set_knobs(0, 0, 0, 0, 0);
        k = 0;
        while (!InstrValid && k < 50) begin
            cycle();
            k++;
        end
        chk("sat_head_valid", InstrValid, 1);
        run(70000);
        chk("stall_saturated", PerfStall, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
